// File: rtl/grid_step_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grid_step_controller_pkg
// Purpose  : Shared constants and types for the heat-map grid step controller.
//            Holds the node value fixed-point layout (signed Q1.4.27), the
//            default row/column field widths and the controller state
//            encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package grid_step_controller_pkg;

   // Node value layout: signed, 4 integer bits, 27 fractional bits.
   localparam int DATA_W    = 32;
   localparam int FRAC_BITS = 27;
   localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;
   localparam logic [DATA_W-1:0] FP_ONE  = 32'h0800_0000;

   // Default field widths for row and column indices.
   localparam int ROW_BITS = 8;
   localparam int COL_BITS = 8;

   // Width of a pixel intensity.
   localparam int COLOR_W = 8;

   typedef enum logic [2:0] {
      ST_INIT_WAIT  = 3'd0,
      ST_IDLE       = 3'd1,
      ST_ISSUE      = 3'd2,
      ST_ARM        = 3'd3,
      ST_WAIT_FLAGS = 3'd4,
      ST_STREAM     = 3'd5,
      ST_ADVANCE    = 3'd6,
      ST_DONE       = 3'd7
   } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/grid_step_controller_heat_to_color.sv
`default_nettype none
// ============================================================================
// Module   : grid_step_controller_heat_to_color
// Purpose  : Combinational map from a signed fixed-point node value to an
//            8-bit intensity. Negative values clamp to 0, values at or above
//            1.0 clamp to full scale, everything in between takes the top
//            eight fractional bits.
// Ports    : value_i  - node value (signed fixed point)
//            color_o  - 8-bit intensity
// Revision : 1.0 - initial release
// ============================================================================
module grid_step_controller_heat_to_color #(
   parameter int DATA_W = grid_step_controller_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] value_i,
   output logic [7:0]        color_o
);
   import grid_step_controller_pkg::*;

   localparam logic [DATA_W-1:0] C_ZERO = DATA_W'(FP_ZERO);
   localparam logic [DATA_W-1:0] C_ONE  = DATA_W'(FP_ONE);

   always_comb begin
      color_o = 8'd0;
      if ($signed(value_i) < $signed(C_ZERO)) begin
         color_o = 8'd0;
      end else if (value_i >= C_ONE) begin
         color_o = 8'hFF;
      end else begin
         color_o = value_i[FRAC_BITS-1 -: 8];
      end
   end

endmodule
`default_nettype wire

// File: rtl/grid_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : grid_step_controller
// Purpose  : Initiator side of the column start/flag step handshake for the
//            heat-map grid. Waits out the column memory init, issues one-cycle
//            start pulses, collects per-column completion flags, tracks row
//            and sweep, and on display sweeps streams one pixel per active
//            column to the VGA writer over valid/ready.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            enable_i             - allow new steps (sampled in IDLE)
//            height_i / width_i   - top row index / last active column index
//            max_sweeps_i         - sweeps to run, 0 = forever
//            disp_div_i           - stream on sweeps divisible by this, 0 = never
//            col_flag_i           - per-column step-done flags
//            col_value_i          - flattened node_center buses
//            start_o              - one-cycle step pulse
//            pix_*                - pixel stream (valid/ready, x, y, colour)
//            cur_row_o            - row of the current/last step
//            sweep_count_o        - completed sweeps
//            busy_o / done_o      - activity / finished status
//            error_o              - sticky flag timeout
// Revision : 1.0 - initial release
// ============================================================================
module grid_step_controller #(
   parameter int NUM_COLS = 32,
   parameter int DATA_W   = grid_step_controller_pkg::DATA_W,
   parameter int ROW_BITS = grid_step_controller_pkg::ROW_BITS,
   parameter int COL_BITS = grid_step_controller_pkg::COL_BITS,
   parameter int TIMEOUT  = 1023
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable_i,
   input  logic [ROW_BITS-1:0]        height_i,
   input  logic [COL_BITS-1:0]        width_i,
   input  logic [15:0]                max_sweeps_i,
   input  logic [7:0]                 disp_div_i,
   input  logic [NUM_COLS-1:0]        col_flag_i,
   input  logic [NUM_COLS*DATA_W-1:0] col_value_i,
   output logic                       start_o,
   output logic                       pix_valid_o,
   input  logic                       pix_ready_i,
   output logic [COL_BITS-1:0]        pix_x_o,
   output logic [ROW_BITS-1:0]        pix_y_o,
   output logic [7:0]                 pix_color_o,
   output logic [ROW_BITS-1:0]        cur_row_o,
   output logic [15:0]                sweep_count_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o
);
   import grid_step_controller_pkg::*;

   localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   // One counter serves both the init wait (up to 2*height+6) and the timeout.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > ROW_BITS + 3) ?
                          $clog2(TIMEOUT + 1) : ROW_BITS + 3;
   localparam logic [COL_BITS-1:0] LAST_COL     = COL_BITS'(NUM_COLS - 1);
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   ctrl_state_e           state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  start_q;
   logic                  pix_valid_q;
   logic [COL_BITS-1:0]   pix_x_q;
   logic [ROW_BITS-1:0]   pix_y_q;
   logic [7:0]            pix_color_q;
   logic [ROW_BITS-1:0]   cur_row_q;
   logic [15:0]           sweep_count_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  error_q;

   logic [COL_BITS-1:0]   w_eff_w;
   logic [NUM_COLS-1:0]   w_mask;
   logic                  w_all_flags;
   logic [DATA_W-1:0]     w_vals [NUM_COLS];
   logic [IDX_W-1:0]      w_sel_idx;
   logic [7:0]            w_color;
   logic [15:0]           w_sweep_mod;
   logic                  w_disp;
   logic [15:0]           w_sweep_next;
   logic [CNT_W-1:0]      w_init_last;

   // Columns beyond the physical array are never waited on or streamed.
   assign w_eff_w = (width_i > LAST_COL) ? LAST_COL : width_i;

   genvar c;
   generate
      for (c = 0; c < NUM_COLS; c = c + 1) begin : g_cols
         assign w_mask[c] = (COL_BITS'(c) <= w_eff_w);
         assign w_vals[c] = col_value_i[c*DATA_W +: DATA_W];
      end
   endgenerate

   assign w_all_flags = &(col_flag_i | ~w_mask);

   // Colour is looked up for the pixel about to be loaded: column 0 when the
   // stream opens, the next column while streaming.
   assign w_sel_idx = (state_q == ST_STREAM) ? (IDX_W'(pix_x_q) + IDX_W'(1)) : '0;

   grid_step_controller_heat_to_color #(
      .DATA_W (DATA_W)
   ) u_heat_to_color (
      .value_i (w_vals[w_sel_idx]),
      .color_o (w_color)
   );

   assign w_sweep_mod  = sweep_count_q % {8'd0, disp_div_i};
   assign w_disp       = (disp_div_i != 8'd0) && (w_sweep_mod == 16'd0);
   assign w_sweep_next = sweep_count_q + 16'd1;
   // Init lasts 2*(height+1)+4 cycles; the counter runs 0..2*height+5.
   assign w_init_last  = CNT_W'({height_i, 1'b0}) + CNT_W'(5);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_INIT_WAIT;
         cnt_q         <= '0;
         start_q       <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_color_q   <= '0;
         cur_row_q     <= '0;
         sweep_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_INIT_WAIT: begin
               if (cnt_q >= w_init_last) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + CNT_W'(1);
                  busy_q <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (enable_i) begin
                  state_q <= ST_ISSUE;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_ARM;
            end
            ST_ARM: begin
               // Columns may still present the previous step's flags here.
               state_q <= ST_WAIT_FLAGS;
               cnt_q   <= '0;
            end
            ST_WAIT_FLAGS: begin
               if (w_all_flags) begin
                  if (w_disp) begin
                     state_q     <= ST_STREAM;
                     pix_valid_q <= 1'b1;
                     pix_x_q     <= '0;
                     pix_y_q     <= cur_row_q;
                     pix_color_q <= w_color;
                  end else begin
                     state_q <= ST_ADVANCE;
                  end
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_STREAM: begin
               // pix_valid_q is always high in this state, so ready alone
               // marks a transfer.
               if (pix_ready_i) begin
                  if (pix_x_q >= w_eff_w) begin
                     pix_valid_q <= 1'b0;
                     state_q     <= ST_ADVANCE;
                  end else begin
                     pix_x_q     <= pix_x_q + COL_BITS'(1);
                     pix_color_q <= w_color;
                  end
               end
            end
            ST_ADVANCE: begin
               busy_q <= 1'b0;
               if (cur_row_q == height_i) begin
                  cur_row_q     <= '0;
                  sweep_count_q <= w_sweep_next;
                  if ((max_sweeps_i != 16'd0) && (w_sweep_next == max_sweeps_i)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cur_row_q <= cur_row_q + ROW_BITS'(1);
                  state_q   <= ST_IDLE;
               end
            end
            ST_DONE: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: begin
               state_q <= ST_INIT_WAIT;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign start_o       = start_q;
   assign pix_valid_o   = pix_valid_q;
   assign pix_x_o       = pix_x_q;
   assign pix_y_o       = pix_y_q;
   assign pix_color_o   = pix_color_q;
   assign cur_row_o     = cur_row_q;
   assign sweep_count_o = sweep_count_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_step_controller
// Purpose  : Directed self-checking bench for grid_step_controller. A small
//            column model answers each start pulse with flags after a set
//            latency; a monitor collects pixel transfers and watches that a
//            stalled pixel holds still.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_step_controller;

   localparam int NUM_COLS = 32;
   localparam int DATA_W   = 32;
   localparam int ROW_BITS = 8;
   localparam int COL_BITS = 8;
   localparam int TIMEOUT  = 1023;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       enable = 1'b0;
   logic [ROW_BITS-1:0]        height = '0;
   logic [COL_BITS-1:0]        width = '0;
   logic [15:0]                max_sweeps = '0;
   logic [7:0]                 disp_div = '0;
   logic [NUM_COLS-1:0]        col_flag;
   logic [NUM_COLS*DATA_W-1:0] col_value = '0;
   logic                       start;
   logic                       pix_valid;
   logic                       pix_ready;
   logic [COL_BITS-1:0]        pix_x;
   logic [ROW_BITS-1:0]        pix_y;
   logic [7:0]                 pix_color;
   logic [ROW_BITS-1:0]        cur_row;
   logic [15:0]                sweep_count;
   logic                       busy;
   logic                       done;
   logic                       error;

   int n_checks = 0;
   int n_pass   = 0;

   // Column model and ready-driver controls
   int                  flag_lat = 6;
   logic [NUM_COLS-1:0] flag_mask = '0;
   logic                ready_toggle = 1'b0;

   // Monitor results
   logic [7:0] qx[$];
   logic [7:0] qy[$];
   logic [7:0] qc[$];
   int         n_stall = 0;
   int         n_stall_bad = 0;

   grid_step_controller #(
      .NUM_COLS (NUM_COLS),
      .DATA_W   (DATA_W),
      .ROW_BITS (ROW_BITS),
      .COL_BITS (COL_BITS),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable_i      (enable),
      .height_i      (height),
      .width_i       (width),
      .max_sweeps_i  (max_sweeps),
      .disp_div_i    (disp_div),
      .col_flag_i    (col_flag),
      .col_value_i   (col_value),
      .start_o       (start),
      .pix_valid_o   (pix_valid),
      .pix_ready_i   (pix_ready),
      .pix_x_o       (pix_x),
      .pix_y_o       (pix_y),
      .pix_color_o   (pix_color),
      .cur_row_o     (cur_row),
      .sweep_count_o (sweep_count),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error)
   );

   initial forever #5 clk = ~clk;

   // Column model: clears flags when it sees start, raises the masked flags
   // flag_lat negedges later.
   initial begin
      int lat_cnt;
      lat_cnt  = 0;
      col_flag = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            col_flag = '0;
            lat_cnt  = 0;
         end else if (start) begin
            col_flag = '0;
            lat_cnt  = flag_lat;
         end else if (lat_cnt != 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) col_flag = flag_mask;
         end
      end
   end

   // VGA writer side: always ready, or alternating 1/0 each cycle.
   initial begin
      pix_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (ready_toggle) pix_ready = ~pix_ready;
         else              pix_ready = 1'b1;
      end
   end

   // Transfer collector and stall-stability watcher.
   logic        stall_pend = 1'b0;
   logic [24:0] stall_snap = '0;
   always @(posedge clk) begin
      if (reset) begin
         stall_pend = 1'b0;
         qx.delete();
         qy.delete();
         qc.delete();
      end else begin
         if (stall_pend) begin
            n_stall = n_stall + 1;
            if ({pix_valid, pix_x, pix_y, pix_color} !== stall_snap)
               n_stall_bad = n_stall_bad + 1;
         end
         stall_pend = pix_valid && !pix_ready;
         stall_snap = {pix_valid, pix_x, pix_y, pix_color};
         if (pix_valid && pix_ready) begin
            qx.push_back(pix_x);
            qy.push_back(pix_y);
            qc.push_back(pix_color);
         end
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Cycles from the first edge after reset release to the edge raising start.
   task automatic measure_init(input string tag, input int exp);
      int n;
      tick();
      n = 0;
      while (!start && n < 300) begin
         tick();
         n++;
      end
      check_value(tag, n, exp);
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n;
      n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      check_value(tag, done, 1);
   endtask

   initial begin
      int k;
      int n_start;
      int found;

      // ---------------- Reset state ----------------
      repeat (3) tick();
      check_value("rst_ctrl", {start, pix_valid, busy, done, error}, 5'b0);
      check_value("rst_data", {pix_x, pix_y, pix_color, cur_row}, 32'h0);
      check_value("rst_sweep", sweep_count, 16'h0);

      // ---------------- 1: init + single step ----------------
      height = 8'd7; width = 8'd3; disp_div = 8'd0; max_sweeps = 16'd0;
      flag_lat = 6; flag_mask = 32'hF; ready_toggle = 1'b0; enable = 1'b1;
      do_reset();
      measure_init("t1_init_delay", 20);           // 2*(7+1)+4
      enable = 1'b0;                               // step finishes, then park in IDLE
      tick();
      check_value("t1_start_one_cycle", start, 0);
      check_value("t1_row_before", cur_row, 0);
      k = 1;
      while (cur_row != 8'd1 && k < 60) begin
         tick();
         k++;
      end
      // Flags land mid-cycle 6 after start: capture at +7, row update at +8.
      check_value("t1_row_latency", k, 8);
      check_value("t1_row_after", cur_row, 1);
      n_start = 0;
      repeat (10) begin
         tick();
         if (start) n_start++;
      end
      check_value("t1_no_restart", n_start, 0);
      check_value("t1_idle_busy", busy, 0);
      check_value("t1_no_pixels", qx.size(), 0);

      // ---------------- 2: full sweep count ----------------
      height = 8'd3; width = 8'd3; max_sweeps = 16'd2; disp_div = 8'd0;
      flag_lat = 2; flag_mask = 32'hF; enable = 1'b1;
      do_reset();
      n_start = 0;
      k = 0;
      while (!done && k < 800) begin
         tick();
         if (start) n_start++;
         k++;
      end
      check_value("t2_starts", n_start, 8);
      check_value("t2_sweeps", sweep_count, 2);
      check_value("t2_done", done, 1);
      check_value("t2_busy", busy, 0);
      check_value("t2_row_wrap", cur_row, 0);
      n_start = 0;
      repeat (20) begin
         tick();
         if (start) n_start++;
      end
      check_value("t2_no_start_after", n_start, 0);

      // ---------------- 3: pixel stream with backpressure ----------------
      height = 8'd0; width = 8'd3; max_sweeps = 16'd1; disp_div = 8'd1;
      flag_lat = 2; flag_mask = 32'hF; enable = 1'b1;
      col_value = '0;
      col_value[0*DATA_W +: DATA_W] = 32'hFC00_0000;  // -0.5
      col_value[1*DATA_W +: DATA_W] = 32'h0200_0000;  // 0.25
      col_value[2*DATA_W +: DATA_W] = 32'h0800_0000;  // 1.0
      col_value[3*DATA_W +: DATA_W] = 32'h07FD_F3B6;  // ~0.999
      ready_toggle = 1'b1;
      do_reset();
      n_stall = 0; n_stall_bad = 0;
      wait_done("t3_done", 400);
      ready_toggle = 1'b0;
      check_value("t3_count", qx.size(), 4);
      if (qx.size() == 4) begin
         check_value("t3_x0", qx[0], 0);
         check_value("t3_x3", qx[3], 3);
         check_value("t3_y", {qy[0], qy[1], qy[2], qy[3]}, 0);
         check_value("t3_c0", qc[0], 0);
         check_value("t3_c1", qc[1], 64);
         check_value("t3_c2", qc[2], 255);
         check_value("t3_c3", qc[3], 255);
      end
      check_value("t3_stalls_seen", (n_stall > 0), 1);
      check_value("t3_stall_hold_bad", n_stall_bad, 0);
      check_value("t3_pix_valid_low", pix_valid, 0);

      // ---------------- 4: inactive columns and clamp ----------------
      for (int c = 0; c < NUM_COLS; c++)
         col_value[c*DATA_W +: DATA_W] = 32'(c) << 19;   // colour c
      height = 8'd0; width = 8'd40; max_sweeps = 16'd1; disp_div = 8'd1;
      flag_lat = 3; flag_mask = 32'hFFFF_FFFF; enable = 1'b1;
      do_reset();
      wait_done("t4a_done", 400);
      check_value("t4a_count", qx.size(), 32);
      if (qx.size() == 32) begin
         for (int i = 0; i < 32; i++) begin
            check_value($sformatf("t4a_x%0d", i), qx[i], i);
            check_value($sformatf("t4a_c%0d", i), qc[i], i);
         end
      end

      width = 8'd2; flag_mask = 32'h7;
      do_reset();
      wait_done("t4b_done", 400);
      check_value("t4b_count", qx.size(), 3);
      if (qx.size() == 3) begin
         check_value("t4b_x", {qx[0], qx[1], qx[2]}, 24'h00_01_02);
         check_value("t4b_c", {qc[0], qc[1], qc[2]}, 24'h00_01_02);
      end

      // ---------------- 5: timeout ----------------
      height = 8'd0; width = 8'd3; max_sweeps = 16'd0; disp_div = 8'd0;
      flag_lat = 2; flag_mask = 32'hD; enable = 1'b1;   // column 1 never flags
      do_reset();
      measure_init("t5_init_delay", 6);            // 2*(0+1)+4
      k = 0;
      while (!error && k < 1300) begin
         tick();
         k++;
      end
      // ARM at +1, WAIT entered at +2, TIMEOUT cycles there -> error at +TIMEOUT+2.
      check_value("t5_timeout_cycles", k, TIMEOUT + 2);
      check_value("t5_done_state", {done, busy, error}, 3'b101);
      n_start = 0;
      repeat (30) begin
         tick();
         if (start) n_start++;
      end
      check_value("t5_error_sticky", error, 1);
      check_value("t5_no_start", n_start, 0);

      // ---------------- 6: reset mid-stream ----------------
      height = 8'd0; width = 8'd5; max_sweeps = 16'd0; disp_div = 8'd1;
      flag_lat = 2; flag_mask = 32'hFFFF_FFFF; enable = 1'b1; ready_toggle = 1'b0;
      do_reset();
      found = 0;
      k = 0;
      while (found == 0 && k < 200) begin
         tick();
         if (pix_valid && pix_x == 8'd2) found = 1;
         k++;
      end
      check_value("t6_reach_x2", found, 1);
      reset = 1'b1;
      tick();
      check_value("t6_ctrl_zero", {start, pix_valid, busy, done, error}, 5'b0);
      check_value("t6_data_zero", {pix_x, pix_y, pix_color, cur_row}, 32'h0);
      check_value("t6_sweep_zero", sweep_count, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      measure_init("t6_reinit_delay", 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
